cpu_phase_sequencer: RTL and testbench
======================================

// Module: cpu_phase_sequencer
// PURPOSE
//   Multi-cycle controller for the yIF/yID/yEX/yDM/yWB/yPC datapath. Replaces the bench-driven
//   clk/INT/repeat loop: boots the PC to an entry point and steps each instruction through
//   FETCH/EXEC/MEM/WB phases. Gates PC, register-file and data-memory activity per phase, and
//   waits on a data-memory ready handshake. Supports free-run, single-step, instruction budget
//   and abort. Sits beside the yC1..yC4 decode; its enables AND with RegWrite/MemRead/MemWrite.
// PARAMETERS
//   CNT_W        16   width of instruction budget/counter
//   MEM_TIMEOUT  15   max cycles in MEM awaiting mem_ready before error halt (>=1)
//   TO_W          4   width of timeout counter (must hold MEM_TIMEOUT)
// PORTS
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   start        in   1      begin run (honoured only in IDLE or HALT)
//   abort        in   1      force HALT from any running state
//   step_mode    in   1      1 = pause after each retired instruction
//   step_req     in   1      release from PAUSE
//   entry_point  in   32     boot PC, sampled with start
//   max_ins      in   CNT_W  instruction budget, sampled with start; 0 = unbounded
//   is_lw        in   1      from yC1, valid in EXEC
//   is_stype     in   1      from yC1, valid in EXEC
//   mem_ready    in   1      data memory access complete
//   int_o        out  1      drives yPC INT (select entryPoint)
//   entry_o      out  32     drives yPC entryPoint (latched entry_point)
//   pc_we        out  1      PC register update enable
//   ir_we        out  1      instruction fetch/latch enable
//   dm_en        out  1      qualifies MemRead/MemWrite
//   rf_we_en     out  1      qualifies RegWrite
//   busy         out  1      state not in {IDLE, PAUSE, HALT}
//   done         out  1      state == HALT
//   err          out  1      sticky memory-timeout flag
//   ins_count    out  CNT_W  instructions retired this run
//   state_o      out  3      current state encoding
// BEHAVIOUR
//   Reset: state=IDLE(0); all outputs 0; entry_o=0; ins_count=0; err=0; timeout ctr=0.
//   States: IDLE=0 BOOT=1 FETCH=2 EXEC=3 MEM=4 WB=5 PAUSE=6 HALT=7. Registered state.
//   Outputs are Moore decodes of state except entry_o, ins_count and err, which are registered.
//   IDLE/HALT: on start -> BOOT; latch entry_point, max_ins; clear ins_count, err. No other
//     transition occurs out of IDLE/HALT.
//   BOOT:  int_o=1, pc_we=1 (PC <= entry_o) -> FETCH. Exactly one cycle.
//   FETCH: ir_we=1 -> EXEC.
//   EXEC:  no enables. (is_lw|is_stype) ? MEM : WB. Timeout ctr cleared.
//   MEM:   dm_en=1 every cycle in state. mem_ready=1 -> WB. Timeout ctr increments each
//     cycle ready is low. Reaching MEM_TIMEOUT -> HALT with err=1.
//   WB:    rf_we_en=1, pc_we=1, ins_count++ (wraps mod 2^CNT_W).
//     Next state: (max_ins!=0 && ins_count+1==max_ins) ? HALT : step_mode ? PAUSE : FETCH.
//   PAUSE: step_req=1 -> FETCH; otherwise hold.
//   Latency: non-memory instruction = 3 cycles (FETCH,EXEC,WB). Memory instruction =
//     4 + (cycles mem_ready low).
//   Priority, any running state (BOOT..PAUSE): abort > timeout > normal transition.
//     abort -> HALT next edge; the in-progress instruction is not retired; err unchanged.
//   start while running is ignored. step_req outside PAUSE is ignored.
//   mem_ready outside MEM is ignored.
//   Async reset mid-run returns to IDLE immediately. All enables drop without waiting for clk.
// TESTING
//   T1 reset: assert rst_n=0 in MEM with dm_en=1 -> dm_en=0, state_o=0 with no clock edge;
//      release -> state stays IDLE.
//   T2 boot/run: entry_point=0x28, max_ins=3, start, 3 ALU ops -> int_o high 1 cycle;
//      entry_o=0x28; done 10 cycles after start edge; ins_count=3.
//   T3 load wait: is_lw=1, mem_ready low 2 cycles then high -> dm_en high 3 cycles;
//      instruction takes 6 cycles; rf_we_en high 1 cycle.
//   T4 timeout: is_stype=1, mem_ready stuck 0 -> HALT after 15 MEM cycles; err=1;
//      ins_count unchanged.
//   T5 step: step_mode=1, max_ins=0 -> PAUSE after each WB; step_req pulse -> FETCH next cycle;
//      200 cycles with no step_req -> ins_count frozen.
//   T6 abort/restart: abort in EXEC -> HALT next edge with count not incremented; start
//      mid-run ignored; start in HALT -> BOOT with ins_count=0, err=0.

Source files
------------

// File: rtl/cpu_phase_sequencer_if.sv
// Handshake and control bundle between the phase sequencer and its surroundings:
// run control in, decode hints and memory ready in, phase enables and status out.
interface cpu_phase_sequencer_if #(
   parameter int CNT_W = 16
);
   logic             start;
   logic             abort;
   logic             step_mode;
   logic             step_req;
   logic [31:0]      entry_point;
   logic [CNT_W-1:0] max_ins;
   logic             is_lw;
   logic             is_stype;
   logic             mem_ready;

   logic             int_o;
   logic [31:0]      entry_o;
   logic             pc_we;
   logic             ir_we;
   logic             dm_en;
   logic             rf_we_en;
   logic             busy;
   logic             done;
   logic             err;
   logic [CNT_W-1:0] ins_count;
   logic [2:0]       state_o;

   modport master (
      output start, abort, step_mode, step_req, entry_point, max_ins,
             is_lw, is_stype, mem_ready,
      input  int_o, entry_o, pc_we, ir_we, dm_en, rf_we_en, busy, done,
             err, ins_count, state_o
   );

   modport slave (
      input  start, abort, step_mode, step_req, entry_point, max_ins,
             is_lw, is_stype, mem_ready,
      output int_o, entry_o, pc_we, ir_we, dm_en, rf_we_en, busy, done,
             err, ins_count, state_o
   );
endinterface

// File: rtl/cpu_phase_sequencer.sv
// Multi-cycle phase controller for the single-cycle datapath: boots the PC,
// then walks each instruction through FETCH/EXEC/(MEM)/WB, gating PC,
// register-file and data-memory activity, with step, budget and abort control.
module cpu_phase_sequencer #(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 15,
   parameter int TO_W        = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   cpu_phase_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      BOOT  = 3'd1,
      FETCH = 3'd2,
      EXEC  = 3'd3,
      MEM   = 3'd4,
      WB    = 3'd5,
      PAUSE = 3'd6,
      HALT  = 3'd7
   } state_t;

   state_t           state;
   state_t           nxt;
   logic             take_start;
   logic             retire;
   logic             timeout;
   logic             running;

   logic [CNT_W-1:0] max_q;
   logic [CNT_W-1:0] cnt_q;
   logic [TO_W-1:0]  to_q;
   logic [31:0]      entry_q;
   logic             err_q;
   logic             int_q, pc_we_q, ir_we_q, dm_q, rf_q, busy_q, done_q;

   assign running = (state != IDLE) && (state != HALT);

   // Next phase plus the retire/timeout side effects; abort overrides everything while running.
   always_comb begin
      nxt        = state;
      take_start = 1'b0;
      retire     = 1'b0;
      timeout    = 1'b0;
      case (state)
         IDLE, HALT: begin
            if (bus.start) begin
               nxt        = BOOT;
               take_start = 1'b1;
            end
         end
         BOOT:  nxt = FETCH;
         FETCH: nxt = EXEC;
         EXEC:  nxt = (bus.is_lw || bus.is_stype) ? MEM : WB;
         MEM: begin
            if (bus.mem_ready) begin
               nxt = WB;
            end else if (to_q == TO_W'(MEM_TIMEOUT - 1)) begin
               nxt     = HALT;
               timeout = 1'b1;
            end
         end
         WB: begin
            retire = 1'b1;
            if ((max_q != '0) && (CNT_W'(cnt_q + 1'b1) == max_q)) begin
               nxt = HALT;
            end else if (bus.step_mode) begin
               nxt = PAUSE;
            end else begin
               nxt = FETCH;
            end
         end
         PAUSE: begin
            if (bus.step_req) begin
               nxt = FETCH;
            end
         end
         default: nxt = IDLE;
      endcase
      // An aborted instruction is neither retired nor flagged as a timeout.
      if (running && bus.abort) begin
         nxt     = HALT;
         retire  = 1'b0;
         timeout = 1'b0;
      end
   end

   // State, registered phase enables (decoded from the upcoming state) and run bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         int_q   <= 1'b0;
         pc_we_q <= 1'b0;
         ir_we_q <= 1'b0;
         dm_q    <= 1'b0;
         rf_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         entry_q <= '0;
         max_q   <= '0;
         cnt_q   <= '0;
         to_q    <= '0;
      end else begin
         state   <= nxt;
         int_q   <= (nxt == BOOT);
         pc_we_q <= (nxt == BOOT) || (nxt == WB);
         ir_we_q <= (nxt == FETCH);
         dm_q    <= (nxt == MEM);
         rf_q    <= (nxt == WB);
         busy_q  <= (nxt != IDLE) && (nxt != PAUSE) && (nxt != HALT);
         done_q  <= (nxt == HALT);

         if (take_start) begin
            entry_q <= bus.entry_point;
            max_q   <= bus.max_ins;
            cnt_q   <= '0;
            err_q   <= 1'b0;
         end else begin
            if (retire) begin
               cnt_q <= cnt_q + 1'b1;
            end
            if (timeout) begin
               err_q <= 1'b1;
            end
         end

         // The wait counter restarts for every instruction and only advances while memory stalls.
         if (state == EXEC) begin
            to_q <= '0;
         end else if ((state == MEM) && !bus.mem_ready) begin
            to_q <= to_q + 1'b1;
         end
      end
   end

   assign bus.state_o   = state;
   assign bus.int_o     = int_q;
   assign bus.entry_o   = entry_q;
   assign bus.pc_we     = pc_we_q;
   assign bus.ir_we     = ir_we_q;
   assign bus.dm_en     = dm_q;
   assign bus.rf_we_en  = rf_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.ins_count = cnt_q;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Bench for cpu_phase_sequencer: fixed run table, hand-written multi-cycle
// corner sequences, and randomized programs predicted by an instruction-level model.
module tb_cpu_phase_sequencer;

   localparam int CNT_W  = 16;
   localparam int MEM_TO = 15;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   cpu_phase_sequencer_if #(.CNT_W(CNT_W)) bus ();

   cpu_phase_sequencer #(
      .CNT_W(CNT_W),
      .MEM_TIMEOUT(MEM_TO),
      .TO_W(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // program seen by the responder: 0 = ALU, 1 = load, 2 = store; dly = cycles mem_ready stays low
   int kind [16];
   int dly  [16];
   int ip      = 0;
   int cur     = 0;
   int mem_cnt = 0;
   bit noise   = 1'b0;

   int c_int, c_dm, c_rf, c_pc;

   // Instruction/data memory responder: supplies decode hints per fetch and delays mem_ready.
   always @(negedge clk) begin
      if (!rst_n) begin
         bus.is_lw     = 1'b0;
         bus.is_stype  = 1'b0;
         bus.mem_ready = 1'b0;
         mem_cnt       = 0;
      end else begin
         if (bus.start) begin
            ip  = 0;
            cur = 0;
         end
         if (bus.ir_we) begin
            cur = ip % 16;
            ip++;
         end
         bus.is_lw    = (kind[cur] == 1);
         bus.is_stype = (kind[cur] == 2);
         if (bus.dm_en) begin
            bus.mem_ready = (mem_cnt == dly[cur]);
            mem_cnt++;
         end else begin
            mem_cnt       = 0;
            bus.mem_ready = noise ? (($urandom & 1) != 0) : 1'b0;
         end
      end
   end

   // Enable-activity counters for the current run, cleared when start is presented.
   always @(negedge clk) begin
      if (bus.start) begin
         c_int = 0; c_dm = 0; c_rf = 0; c_pc = 0;
      end else begin
         c_int += int'(bus.int_o);
         c_dm  += int'(bus.dm_en);
         c_rf  += int'(bus.rf_we_en);
         c_pc  += int'(bus.pc_we);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic do_start(input logic [31:0] ep, input int mx);
      @(posedge clk); #1;
      bus.entry_point = ep;
      bus.max_ins     = CNT_W'(mx);
      bus.start       = 1'b1;
      @(posedge clk); #1;
      bus.start       = 1'b0;
   endtask

   task automatic wait_done(input int bound, output int cyc);
      cyc = 0;
      while (!bus.done && cyc < bound) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   // Instruction-level prediction: boot cycle, then 3 cycles per ALU op and
   // 4+stall per memory op, stopping with err once a stall reaches the timeout.
   task automatic model(input int n, output int cyc, output int cnt, output int er, output int dm);
      cyc = 1; cnt = 0; er = 0; dm = 0;
      for (int i = 0; i < n; i++) begin
         if (kind[i] == 0) begin
            cyc += 3;
            cnt++;
         end else if (dly[i] >= MEM_TO) begin
            cyc += 2 + MEM_TO;
            dm  += MEM_TO;
            er   = 1;
            break;
         end else begin
            cyc += 4 + dly[i];
            dm  += dly[i] + 1;
            cnt++;
         end
      end
   endtask

   task automatic check_run(input string tag, input logic [31:0] ep, input int e_cyc,
                            input int e_cnt, input int e_err, input int e_dm);
      int cyc;
      wait_done(400, cyc);
      chk({tag, " cycles"},    64'(cyc),            64'(e_cyc));
      chk({tag, " ins_count"}, 64'(bus.ins_count),  64'(e_cnt));
      chk({tag, " err"},       64'(bus.err),        64'(e_err));
      chk({tag, " dm_en cyc"}, 64'(c_dm),           64'(e_dm));
      chk({tag, " rf_we cyc"}, 64'(c_rf),           64'(e_cnt));
      chk({tag, " pc_we cyc"}, 64'(c_pc),           64'(1 + e_cnt));
      chk({tag, " int cyc"},   64'(c_int),          64'(1));
      chk({tag, " entry_o"},   64'(bus.entry_o),    64'(ep));
   endtask

   typedef struct {
      logic [31:0] ep;
      int          mx;
      logic [7:0]  kinds;   // 2 bits per instruction
      logic [19:0] dlys;    // 5 bits per instruction
      int          e_cyc;
      int          e_cnt;
      int          e_err;
      int          e_dm;
   } vec_t;

   vec_t tbl [6];

   initial begin
      int cyc, cnt, er, dm, n;
      logic [31:0] ep;

      tbl[0] = '{32'h28,  3, 8'h00, 20'd0,   10, 3, 0, 0};   // three ALU ops
      tbl[1] = '{32'h100, 1, 8'h01, 20'd2,    7, 1, 0, 3};   // load, 2 stall cycles
      tbl[2] = '{32'h0,   2, 8'h02, 20'd31,  18, 0, 1, 15};  // store, ready stuck low
      tbl[3] = '{32'h44,  4, 8'h21, 20'h400, 16, 4, 0, 3};   // lw, alu, sw(1), alu
      tbl[4] = '{32'h8,   1, 8'h02, 20'd14,  19, 1, 0, 15};  // ready on last allowed cycle
      tbl[5] = '{32'hC0,  3, 8'h04, 20'd640, 21, 1, 1, 15};  // timeout on second instruction

      bus.start       = 1'b0;
      bus.abort       = 1'b0;
      bus.step_mode   = 1'b0;
      bus.step_req    = 1'b0;
      bus.entry_point = '0;
      bus.max_ins     = '0;
      for (int i = 0; i < 16; i++) begin
         kind[i] = 0;
         dly[i]  = 0;
      end

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("reset state_o", 64'(bus.state_o), 64'(0));
      chk("reset enables",
          64'({bus.int_o, bus.pc_we, bus.ir_we, bus.dm_en, bus.rf_we_en, bus.busy, bus.done, bus.err}),
          64'(0));
      chk("reset entry_o",   64'(bus.entry_o),   64'(0));
      chk("reset ins_count", 64'(bus.ins_count), 64'(0));

      // table of complete runs
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 16; i++) begin
            kind[i] = (i < 4) ? int'(tbl[r].kinds[2*i +: 2]) : 0;
            dly[i]  = (i < 4) ? int'(tbl[r].dlys[5*i +: 5]) : 0;
         end
         do_start(tbl[r].ep, tbl[r].mx);
         check_run($sformatf("tbl%0d", r), tbl[r].ep, tbl[r].e_cyc, tbl[r].e_cnt,
                   tbl[r].e_err, tbl[r].e_dm);
      end

      // restart from HALT with err set, start while running, abort in EXEC
      for (int i = 0; i < 16; i++) begin
         kind[i] = 0;
         dly[i]  = 0;
      end
      do_start(32'h40, 0);
      chk("restart state BOOT", 64'(bus.state_o),   64'(1));
      chk("restart count clr",  64'(bus.ins_count), 64'(0));
      chk("restart err clr",    64'(bus.err),       64'(0));
      chk("restart int_o",      64'(bus.int_o),     64'(1));
      @(posedge clk); #1;
      bus.entry_point = 32'h99;
      bus.start       = 1'b1;
      @(posedge clk); #1;
      bus.start       = 1'b0;
      chk("start ignored state", 64'(bus.state_o), 64'(3));
      chk("start ignored entry", 64'(bus.entry_o), 64'(32'h40));
      repeat (3) @(posedge clk);
      #1;
      chk("second EXEC state", 64'(bus.state_o),   64'(3));
      chk("second EXEC count", 64'(bus.ins_count), 64'(1));
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      chk("abort state HALT",  64'(bus.state_o),   64'(7));
      chk("abort done",        64'(bus.done),      64'(1));
      chk("abort not retired", 64'(bus.ins_count), 64'(1));
      chk("abort err",         64'(bus.err),       64'(0));

      // single-step
      bus.step_mode = 1'b1;
      do_start(32'h200, 0);
      repeat (4) @(posedge clk);
      #1;
      chk("step PAUSE state", 64'(bus.state_o),   64'(6));
      chk("step PAUSE busy",  64'(bus.busy),      64'(0));
      chk("step count 1",     64'(bus.ins_count), 64'(1));
      repeat (200) @(posedge clk);
      #1;
      chk("step frozen count", 64'(bus.ins_count), 64'(1));
      chk("step frozen state", 64'(bus.state_o),   64'(6));
      bus.step_req = 1'b1;
      @(posedge clk); #1;
      bus.step_req = 1'b0;
      chk("step release FETCH", 64'(bus.state_o), 64'(2));
      chk("step release ir_we", 64'(bus.ir_we),   64'(1));
      repeat (3) @(posedge clk);
      #1;
      chk("step PAUSE again", 64'(bus.state_o),   64'(6));
      chk("step count 2",     64'(bus.ins_count), 64'(2));
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      chk("abort from PAUSE", 64'(bus.state_o), 64'(7));
      bus.step_mode = 1'b0;

      // randomized programs with noise on ignored inputs
      noise        = 1'b1;
      bus.step_req = 1'b1;
      for (int r = 0; r < 25; r++) begin
         n  = $urandom_range(10, 1);
         ep = $urandom;
         for (int i = 0; i < 16; i++) begin
            kind[i] = $urandom_range(2, 0);
            dly[i]  = ($urandom_range(7, 0) == 0) ? $urandom_range(17, 13) : $urandom_range(4, 0);
         end
         model(n, cyc, cnt, er, dm);
         do_start(ep, n);
         check_run($sformatf("rnd%0d", r), ep, cyc, cnt, er, dm);
      end
      noise        = 1'b0;
      bus.step_req = 1'b0;

      // asynchronous reset while in MEM
      for (int i = 0; i < 16; i++) begin
         kind[i] = 1;
         dly[i]  = 10;
      end
      do_start(32'h300, 1);
      cyc = 0;
      while (!bus.dm_en && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("mid-run dm_en high", 64'(bus.dm_en), 64'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("async rst dm_en",   64'(bus.dm_en),   64'(0));
      chk("async rst state_o", 64'(bus.state_o), 64'(0));
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("post rst state_o", 64'(bus.state_o), 64'(0));
      chk("post rst busy",    64'(bus.busy),    64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
